// File: rtl/bombe_pkg.sv
// Shared definitions for the bombe drum-bank controllers: alphabet size,
// rotor position width, sweep FSM encoding and packed-position helpers.
package bombe_pkg;

    localparam int ALPHA          = 26;
    localparam int POS_W          = 5;
    localparam int TOTAL_SETTINGS = ALPHA * ALPHA * ALPHA;

    // A setting packed as {pos2, pos1, pos0}, pos0 in the low bits.
    localparam int HIT_W    = 3 * POS_W;
    localparam int POS0_LSB = 0;
    localparam int POS1_LSB = POS_W;
    localparam int POS2_LSB = 2 * POS_W;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_WAIT    = 3'd2,
        S_RECORD  = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5
    } sweep_state_t;

    function automatic logic [HIT_W-1:0] pack_pos(input logic [POS_W-1:0] p0,
                                                  input logic [POS_W-1:0] p1,
                                                  input logic [POS_W-1:0] p2);
        return {p2, p1, p0};
    endfunction

endpackage

// File: rtl/bombe_position_sweeper_if.sv
// Control, drum-bank and hit-drain signals of the position sweeper.
// slave = the sweeper itself, master = whoever drives it (HPS bus + bank).
interface bombe_position_sweeper_if;
    import bombe_pkg::*;

    logic             start;
    logic             abort;
    logic [POS_W-1:0] start_position_0;
    logic [POS_W-1:0] start_position_1;
    logic [POS_W-1:0] start_position_2;
    logic [POS_W-1:0] init_rotor_position_0;
    logic [POS_W-1:0] init_rotor_position_1;
    logic [POS_W-1:0] init_rotor_position_2;
    logic             bank_reset;
    logic             bank_done;
    logic             bank_fault;
    logic             busy;
    logic             sweep_done;
    logic             hit_valid;
    logic             hit_ready;
    logic [HIT_W-1:0] hit_position;
    logic [15:0]      hit_count;
    logic [15:0]      timeout_count;

    modport master (
        output start, abort, start_position_0, start_position_1, start_position_2,
               bank_done, bank_fault, hit_ready,
        input  init_rotor_position_0, init_rotor_position_1, init_rotor_position_2,
               bank_reset, busy, sweep_done, hit_valid, hit_position,
               hit_count, timeout_count
    );

    modport slave (
        input  start, abort, start_position_0, start_position_1, start_position_2,
               bank_done, bank_fault, hit_ready,
        output init_rotor_position_0, init_rotor_position_1, init_rotor_position_2,
               bank_reset, busy, sweep_done, hit_valid, hit_position,
               hit_count, timeout_count
    );

endinterface

// File: rtl/bombe_position_sweeper_hit_fifo.sv
// Small synchronous FIFO holding recorded hits. A pop on a full FIFO frees
// the slot in the same cycle, so o_can_push already accounts for it.
module hit_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_can_push,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop   = i_pop && !w_empty;
    assign o_can_push = !w_full || w_do_pop;
    assign w_do_push  = i_push && o_can_push;
    assign o_valid    = !w_empty;
    assign o_data     = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Read/write pointers; the extra MSB tells full from empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: an empty FIFO never exposes it.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/bombe_position_sweeper.sv
// Steps the three initial rotor positions through every setting, re-arms the
// drum bank for each one and queues fault-free stops in the hit FIFO.
module bombe_position_sweeper
    import bombe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int FIFO_DEPTH     = 8,
    parameter int ALPHA          = bombe_pkg::ALPHA
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    bombe_position_sweeper_if.slave io_bus
);
    localparam int               WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [POS_W-1:0] LAST   = POS_W'(ALPHA - 1);

    sweep_state_t      r_state;
    logic [POS_W-1:0]  r_pos0, r_pos1, r_pos2;
    logic [HIT_W-1:0]  r_snap;
    logic [WAIT_W-1:0] r_wait;
    logic              r_arm_2nd;
    logic              r_bank_reset;
    logic              r_busy;
    logic              r_sweep_done;
    logic [15:0]       r_hit_count;
    logic [15:0]       r_timeout_count;

    logic              w_wrap0, w_wrap1, w_wrap2;
    logic [POS_W-1:0]  w_nxt0, w_nxt1, w_nxt2;
    logic [HIT_W-1:0]  w_cur, w_nxt;
    logic              w_can_push;
    logic              w_push;
    logic [POS_W-1:0]  w_st0, w_st1, w_st2;

    // Out-of-range start positions collapse to 0.
    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] p);
        return (32'(p) < ALPHA) ? p : '0;
    endfunction

    assign w_st0 = clamp_pos(io_bus.start_position_0);
    assign w_st1 = clamp_pos(io_bus.start_position_1);
    assign w_st2 = clamp_pos(io_bus.start_position_2);
    assign w_cur = pack_pos(r_pos0, r_pos1, r_pos2);

    // Odometer step: pos0 fastest, carries ripple into pos1 then pos2.
    always_comb begin
        w_wrap0 = (r_pos0 == LAST);
        w_wrap1 = (r_pos1 == LAST);
        w_wrap2 = (r_pos2 == LAST);
        w_nxt0  = w_wrap0 ? '0 : r_pos0 + POS_W'(1);
        w_nxt1  = r_pos1;
        w_nxt2  = r_pos2;
        if (w_wrap0) w_nxt1 = w_wrap1 ? '0 : r_pos1 + POS_W'(1);
        if (w_wrap0 && w_wrap1) w_nxt2 = w_wrap2 ? '0 : r_pos2 + POS_W'(1);
        w_nxt = pack_pos(w_nxt0, w_nxt1, w_nxt2);
    end

    assign w_push = (r_state == S_RECORD) && w_can_push;

    // Sweep sequencer; every output it drives is registered here.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state         <= S_IDLE;
            r_pos0          <= '0;
            r_pos1          <= '0;
            r_pos2          <= '0;
            r_snap          <= '0;
            r_wait          <= '0;
            r_arm_2nd       <= 1'b0;
            r_bank_reset    <= 1'b1;
            r_busy          <= 1'b0;
            r_sweep_done    <= 1'b0;
            r_hit_count     <= '0;
            r_timeout_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (io_bus.start) begin
                        r_pos0          <= w_st0;
                        r_pos1          <= w_st1;
                        r_pos2          <= w_st2;
                        r_snap          <= pack_pos(w_st0, w_st1, w_st2);
                        r_hit_count     <= '0;
                        r_timeout_count <= '0;
                        r_sweep_done    <= 1'b0;
                        r_busy          <= 1'b1;
                        r_bank_reset    <= 1'b1;
                        r_arm_2nd       <= 1'b0;
                        r_state         <= S_ARM;
                    end
                end
                // Two reset cycles so the bank leaves reset on a clean boundary.
                S_ARM: begin
                    if (r_arm_2nd) begin
                        r_bank_reset <= 1'b0;
                        r_wait       <= '0;
                        r_state      <= S_WAIT;
                    end else begin
                        r_arm_2nd <= 1'b1;
                    end
                end
                S_WAIT: begin
                    r_wait <= r_wait + WAIT_W'(1);
                    if (io_bus.bank_fault) begin
                        r_state <= S_ADVANCE;
                    end else if (io_bus.bank_done) begin
                        r_state <= S_RECORD;
                    end else if (r_wait == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        if (r_timeout_count != 16'hFFFF)
                            r_timeout_count <= r_timeout_count + 16'd1;
                        r_state <= S_ADVANCE;
                    end
                end
                // Stall here while the FIFO is full; a hit is never lost.
                S_RECORD: begin
                    if (w_can_push) begin
                        if (r_hit_count != 16'hFFFF)
                            r_hit_count <= r_hit_count + 16'd1;
                        r_state <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    r_pos0       <= w_nxt0;
                    r_pos1       <= w_nxt1;
                    r_pos2       <= w_nxt2;
                    r_bank_reset <= 1'b1;
                    r_arm_2nd    <= 1'b0;
                    if (w_nxt == r_snap) begin
                        r_busy       <= 1'b0;
                        r_sweep_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_state <= S_ARM;
                    end
                end
                default: begin
                    r_bank_reset <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
            // Abort wins over whatever the current state decided.
            if (io_bus.abort && r_busy) begin
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                r_bank_reset <= 1'b1;
                r_sweep_done <= 1'b0;
            end
        end
    end

    hit_fifo #(
        .WIDTH (HIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_hit_fifo (
        .i_clk      (i_clk),
        .i_rst_n    (i_reset),
        .i_push     (w_push),
        .i_data     (w_cur),
        .o_can_push (w_can_push),
        .i_pop      (io_bus.hit_ready),
        .o_valid    (io_bus.hit_valid),
        .o_data     (io_bus.hit_position)
    );

    assign io_bus.init_rotor_position_0 = r_pos0;
    assign io_bus.init_rotor_position_1 = r_pos1;
    assign io_bus.init_rotor_position_2 = r_pos2;
    assign io_bus.bank_reset            = r_bank_reset;
    assign io_bus.busy                  = r_busy;
    assign io_bus.sweep_done            = r_sweep_done;
    assign io_bus.hit_count             = r_hit_count;
    assign io_bus.timeout_count         = r_timeout_count;

endmodule

// File: tb/tb_bombe_position_sweeper.sv
// Bench for bombe_position_sweeper: three instances run side by side.
// u_a: reset, single-hit full sweep, done+fault collision.
// u_b: wrap-around sweep from (25,25,25), out-of-range start values.
// u_c: short timeout + abort, shallow FIFO back-pressure.
module tb_bombe_position_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst_n, b_rst_n, c_rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    bombe_position_sweeper_if a_if ();
    bombe_position_sweeper_if b_if ();
    bombe_position_sweeper_if c_if ();

    bombe_position_sweeper u_a (.i_clk(clk), .i_reset(a_rst_n), .io_bus(a_if));
    bombe_position_sweeper u_b (.i_clk(clk), .i_reset(b_rst_n), .io_bus(b_if));
    bombe_position_sweeper #(.TIMEOUT_CYCLES(4), .FIFO_DEPTH(4))
        u_c (.i_clk(clk), .i_reset(c_rst_n), .io_bus(c_if));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [14:0] pk(input int p0, input int p1, input int p2);
        return {5'(p2), 5'(p1), 5'(p0)};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- drum bank stubs ----------------
    int          a_mode = 0;
    int          c_mode = 0;
    logic [14:0] a_pos, b_pos, c_pos;
    assign a_pos = {a_if.init_rotor_position_2, a_if.init_rotor_position_1, a_if.init_rotor_position_0};
    assign b_pos = {b_if.init_rotor_position_2, b_if.init_rotor_position_1, b_if.init_rotor_position_0};
    assign c_pos = {c_if.init_rotor_position_2, c_if.init_rotor_position_1, c_if.init_rotor_position_0};

    // mode 1: only (3,1,0) completes; mode 2: (1,0,0) done+fault, (2,0,0) done
    assign a_if.bank_done  = !a_if.bank_reset &&
        ((a_mode == 1 && a_pos == 15'h0023) ||
         (a_mode == 2 && (a_pos == 15'h0001 || a_pos == 15'h0002)));
    assign a_if.bank_fault = !a_if.bank_reset &&
        ((a_mode == 1 && a_pos != 15'h0023) || (a_mode == 2 && a_pos != 15'h0002));
    assign b_if.bank_done  = 1'b0;
    assign b_if.bank_fault = !b_if.bank_reset;
    assign c_if.bank_done  = !c_if.bank_reset && (c_mode == 1);
    assign c_if.bank_fault = 1'b0;

    // ---------------- monitors / scoreboards ----------------
    logic        a_prev_br = 1'b1, b_prev_br = 1'b1, c_prev_br = 1'b1;
    int          a_settings = 0, b_settings = 0, c_settings = 0;
    int          a_pops = 0, c_pops = 0;
    logic [14:0] q_a[$];
    logic [14:0] q_c[$];
    logic [14:0] b_first, b_second, b_last;

    always @(negedge clk) begin
        if (a_prev_br && !a_if.bank_reset) begin
            a_settings++;
            if (a_if.bank_done && !a_if.bank_fault)
                q_a.push_back(a_mode == 1 ? 15'h0023 : 15'h0002);
        end
        a_prev_br = a_if.bank_reset;
        if (a_if.hit_valid && a_if.hit_ready) begin
            a_pops++;
            if (q_a.size() == 0) chk("a_pop_expected", q_a.size(), 1);
            else chk("a_pop_pos", a_if.hit_position, q_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_prev_br && !b_if.bank_reset) begin
            b_settings++;
            if (b_settings == 1) b_first = b_pos;
            if (b_settings == 2) b_second = b_pos;
            b_last = b_pos;
        end
        b_prev_br = b_if.bank_reset;
    end

    always @(negedge clk) begin
        if (c_prev_br && !c_if.bank_reset) begin
            if (c_if.bank_done)
                q_c.push_back(pk(c_settings % 26, (c_settings / 26) % 26, c_settings / 676));
            c_settings++;
        end
        c_prev_br = c_if.bank_reset;
        if (c_if.hit_valid && c_if.hit_ready) begin
            c_pops++;
            if (q_c.size() == 0) chk("c_pop_expected", q_c.size(), 1);
            else chk("c_pop_pos", c_if.hit_position, q_c.pop_front());
        end
    end

    // ---------------- instance A ----------------
    task automatic seq_a();
        int n;
        // reset in the middle of WAIT
        a_if.start_position_0 = 5; a_if.start_position_1 = 6; a_if.start_position_2 = 7;
        a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
        tick(10);
        chk("a_wait_busy", a_if.busy, 1);
        chk("a_wait_bank_reset", a_if.bank_reset, 0);
        chk("a_wait_pos", a_pos, pk(5, 6, 7));
        #2 a_rst_n = 1'b0;
        #1;
        chk("a_rst_busy", a_if.busy, 0);
        chk("a_rst_bank_reset", a_if.bank_reset, 1);
        chk("a_rst_hit_valid", a_if.hit_valid, 0);
        chk("a_rst_pos", a_pos, 0);
        tick(1); a_rst_n = 1'b1;
        tick(10);
        chk("a_idle_busy", a_if.busy, 0);
        chk("a_idle_bank_reset", a_if.bank_reset, 1);
        chk("a_idle_pos", a_pos, 0);
        chk("a_idle_sweep_done", a_if.sweep_done, 0);

        // full sweep with one hit at (3,1,0); a stray start mid-sweep is ignored
        a_mode = 1; a_settings = 0; a_pops = 0; a_if.hit_ready = 1'b1;
        a_if.start_position_0 = 0; a_if.start_position_1 = 0; a_if.start_position_2 = 0;
        a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
        n = 0;
        while (!a_if.sweep_done && n < 80000) begin
            a_if.start = (n == 1000);
            if (n == 1000) begin
                a_if.start_position_0 = 9; a_if.start_position_1 = 9; a_if.start_position_2 = 9;
            end
            tick(1); n++;
        end
        a_if.start = 1'b0;
        chk("a_sweep_done", a_if.sweep_done, 1);
        chk("a_settings", a_settings, 17576);
        chk("a_hit_count", a_if.hit_count, 1);
        chk("a_timeout_count", a_if.timeout_count, 0);
        chk("a_pops", a_pops, 1);
        chk("a_queue_left", q_a.size(), 0);
        chk("a_done_busy", a_if.busy, 0);
        chk("a_done_bank_reset", a_if.bank_reset, 1);

        // done and fault together at (1,0,0) must not record
        a_mode = 2; a_settings = 0; a_pops = 0;
        a_if.start_position_0 = 0; a_if.start_position_1 = 0; a_if.start_position_2 = 0;
        a_if.start = 1'b1; tick(1); a_if.start = 1'b0;
        chk("a_restart_sweep_done", a_if.sweep_done, 0);
        n = 0;
        while (a_settings < 6 && n < 300) begin tick(1); n++; end
        chk("a_collide_progress", a_settings >= 6, 1);
        a_if.abort = 1'b1; tick(1); a_if.abort = 1'b0;
        tick(4);
        chk("a_collide_hit_count", a_if.hit_count, 1);
        chk("a_collide_pops", a_pops, 1);
        chk("a_collide_queue", q_a.size(), 0);
        chk("a_abort_busy", a_if.busy, 0);
        chk("a_abort_sweep_done", a_if.sweep_done, 0);
    endtask

    // ---------------- instance B ----------------
    task automatic seq_b();
        int n;
        b_settings = 0;
        b_if.start_position_0 = 25; b_if.start_position_1 = 25; b_if.start_position_2 = 25;
        b_if.start = 1'b1; tick(1); b_if.start = 1'b0;
        n = 0;
        while (!b_if.sweep_done && n < 80000) begin tick(1); n++; end
        chk("b_sweep_done", b_if.sweep_done, 1);
        chk("b_settings", b_settings, 17576);
        chk("b_first", b_first, pk(25, 25, 25));
        chk("b_after_wrap", b_second, pk(0, 0, 0));
        chk("b_last", b_last, pk(24, 25, 25));
        chk("b_hit_count", b_if.hit_count, 0);

        // out-of-range start values read as 0
        b_settings = 0;
        b_if.start_position_0 = 30; b_if.start_position_1 = 1; b_if.start_position_2 = 31;
        b_if.start = 1'b1; tick(1); b_if.start = 1'b0;
        chk("b_restart_sweep_done", b_if.sweep_done, 0);
        chk("b_restart_busy", b_if.busy, 1);
        n = 0;
        while (b_settings < 1 && n < 50) begin tick(1); n++; end
        chk("b_clamped_first", b_first, pk(0, 1, 0));
        b_if.abort = 1'b1; tick(1); b_if.abort = 1'b0;
    endtask

    // ---------------- instance C ----------------
    task automatic seq_c();
        int n;
        // silent bank, abort after the third timeout
        c_mode = 0;
        c_if.start_position_0 = 0; c_if.start_position_1 = 0; c_if.start_position_2 = 0;
        c_if.start = 1'b1; tick(1); c_if.start = 1'b0;
        n = 0;
        while (c_if.timeout_count != 3 && n < 200) begin tick(1); n++; end
        chk("c_third_timeout", c_if.timeout_count, 3);
        c_if.abort = 1'b1; tick(1); c_if.abort = 1'b0;
        tick(8);
        chk("c_abort_timeouts", c_if.timeout_count, 3);
        chk("c_abort_busy", c_if.busy, 0);
        chk("c_abort_bank_reset", c_if.bank_reset, 1);
        chk("c_abort_sweep_done", c_if.sweep_done, 0);

        // every setting hits, nobody drains: stall after four
        c_mode = 1; c_settings = 0; c_pops = 0; c_if.hit_ready = 1'b0;
        c_if.start = 1'b1; tick(1); c_if.start = 1'b0;
        tick(60);
        chk("c_stall_busy", c_if.busy, 1);
        chk("c_stall_hits", c_if.hit_count, 4);
        chk("c_stall_valid", c_if.hit_valid, 1);
        chk("c_stall_bank_reset", c_if.bank_reset, 0);
        chk("c_stall_pos", c_pos, pk(4, 0, 0));
        tick(10);
        chk("c_stall_pos_frozen", c_pos, pk(4, 0, 0));
        chk("c_stall_settings", c_settings, 5);
        c_if.hit_ready = 1'b1;
        n = 0;
        while (c_if.hit_count != 5 && n < 50) begin tick(1); n++; end
        chk("c_fifth_hit", c_if.hit_count, 5);
        c_if.abort = 1'b1; tick(1); c_if.abort = 1'b0;
        tick(8);
        chk("c_drain_pops", c_pops, 5);
        chk("c_drain_queue", q_c.size(), 0);
        chk("c_drain_valid", c_if.hit_valid, 0);
        chk("c_drain_busy", c_if.busy, 0);
    endtask

    initial begin
        foreach (q_a[i]) q_a.delete(i);
        a_if.start = 0; a_if.abort = 0; a_if.hit_ready = 0;
        a_if.start_position_0 = 0; a_if.start_position_1 = 0; a_if.start_position_2 = 0;
        b_if.start = 0; b_if.abort = 0; b_if.hit_ready = 1;
        b_if.start_position_0 = 0; b_if.start_position_1 = 0; b_if.start_position_2 = 0;
        c_if.start = 0; c_if.abort = 0; c_if.hit_ready = 0;
        c_if.start_position_0 = 0; c_if.start_position_1 = 0; c_if.start_position_2 = 0;
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        tick(3);
        chk("a_por_bank_reset", a_if.bank_reset, 1);
        chk("c_por_hit_count", c_if.hit_count, 0);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        tick(2);
        fork
            seq_a();
            seq_b();
            seq_c();
        join
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bombe_position_sweeper.md
Name: bombe_position_sweeper

Overview:
- Upstream controller for the drum bank. Steps the three initial rotor positions through all 26^3 = 17576 settings.
- For each setting: re-arms the bank with a reset pulse, waits for bank_done or bank_fault, and records fault-free stops in a small hit FIFO.
- The HPS-side bus interface drains the FIFO.

Parameters:
- TIMEOUT_CYCLES, 1023: maximum WAIT cycles per setting before the setting is abandoned.
- FIFO_DEPTH, 8: hit FIFO entries; power of two, minimum 2.
- ALPHA, 26: alphabet size; positions run 0..ALPHA-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep when idle.
- abort  in  1  level; cancels a sweep in progress.
- start_position_0/1/2  in  5 each  first setting of the sweep; values >= ALPHA are treated as 0.
- init_rotor_position_0/1/2  out  5 each  current setting driven to the drum bank.
- bank_reset  out  1  synchronous active-high re-arm pulse to the drum bank.
- bank_done  in  1  drum bank completion.
- bank_fault  in  1  drum bank contradiction.
- busy  out  1  sweep in progress.
- sweep_done  out  1  high from the end of a completed sweep until the next start.
- hit_valid  out  1  FIFO non-empty.
- hit_ready  in  1  consumer pop; a pop occurs when hit_valid && hit_ready.
- hit_position  out  15  FIFO head, packed {pos2, pos1, pos0}.
- hit_count  out  16  hits recorded in the current sweep (saturating).
- timeout_count  out  16  settings abandoned on timeout (saturating).

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE; FIFO is emptied.
  - All counters and positions are 0; bank_reset=1; busy=0; sweep_done=0; hit_valid=0.
- States: IDLE, ARM, WAIT, RECORD, ADVANCE, DONE.
- IDLE:
  - bank_reset=1.
  - On start: latch the start positions into the position registers and into a start snapshot.
  - Clear hit_count and timeout_count; do not clear the FIFO; go to ARM.
- ARM:
  - bank_reset=1 for exactly 2 cycles. This covers the bank's INIT/WRITE sequencing, which needs reset deasserted on a clean boundary.
  - Then go to WAIT with bank_reset=0.
- WAIT:
  - A wait counter increments each cycle.
  - bank_fault=1 (with or without bank_done): go to ADVANCE, no hit. Fault has priority.
  - bank_done=1 && bank_fault=0: go to RECORD.
  - Counter reaches TIMEOUT_CYCLES: timeout_count++, go to ADVANCE.
- RECORD:
  - If the FIFO is not full: push the current {pos2, pos1, pos0}, hit_count++, go to ADVANCE.
  - If the FIFO is full: stall in RECORD with positions frozen and bank_reset=0. Hits are never dropped.
- ADVANCE:
  - Odometer step: pos0++. On pos0 wrap (ALPHA-1 to 0), carry to pos1; on pos1 wrap, carry to pos2; pos2 wraps freely.
  - If the new setting equals the start snapshot: go to DONE; otherwise go to ARM.
  - Total settings visited per sweep is exactly 17576, including the start setting.
- DONE:
  - sweep_done=1, busy=0, bank_reset=1.
  - start begins a new sweep, clears sweep_done, and follows the IDLE start action.
- busy=1 in ARM, WAIT, RECORD and ADVANCE.
- start while busy is ignored.
- abort while busy: go to IDLE on the next edge. bank_reset=1; FIFO contents and counters are retained; sweep_done stays 0.
- FIFO:
  - Push and pop in the same cycle is allowed; when full, the simultaneous pop frees space and the push is accepted that cycle.
  - hit_position is combinational from the head entry; an empty FIFO reads 0.
- Counters saturate at 16'hFFFF.
- Per-setting latency: 2 (ARM) + WAIT cycles + 1 (ADVANCE), plus 1 RECORD cycle on a hit.

Decomposition:
- Shared package bombe_pkg:
  - ALPHA, POS_W=5, TOTAL_SETTINGS=17576.
  - State encoding localparams.
  - Packed-position helper constants, used by the sweeper and later by the result collector.
- One sub-module: hit_fifo (parameterised width/depth synchronous FIFO, same async active-low reset), instantiated with width 15.

Test Plan:
1. Reset low mid-WAIT -> immediately busy=0, bank_reset=1, hit_valid=0, init_rotor_position_*=0; after release the block stays IDLE until start.
2. Stub bank: fault on every setting except (pos0=3, pos1=1, pos2=0), which gets done. Start at (0,0,0), hit_ready=1 -> exactly one pop with hit_position=15'h0023; sweep_done after 17576 settings; hit_count=1; timeout_count=0.
3. Start at (25,25,25), stub faults immediately -> the setting after the first ADVANCE is (0,0,0); the final setting before DONE is (24,25,25).
4. TIMEOUT_CYCLES=4, silent stub, abort asserted after the third timeout -> timeout_count=3, IDLE, bank_reset=1, sweep_done=0.
5. FIFO_DEPTH=4, stub gives done on every setting, hit_ready=0 -> after 4 hits the block stalls in RECORD with busy=1 and positions frozen. Raise hit_ready -> hits pop in order (0,0,0),(1,0,0),(2,0,0),(3,0,0), then (4,0,0) is recorded.
6. Stub asserts bank_done and bank_fault in the same cycle -> no push; hit_count unchanged; ADVANCE taken.
